mips_muldiv_unit: RTL and testbench
===================================

# mips_muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. Sits beside the execute-stage ALU; accepts MULT/MULTU/DIV/DIVU from execute via a valid/ready handshake and holds the result in HI/LO for MFHI/MFLO. Supports MTHI/MTLO writes and pipeline flush. Radix-2, one result bit per cycle, data width set by XLEN.

## Interface
- XLEN, 32, operand/HI/LO width; any value ≥ 4.
- CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden).

- clock  in  1  single clock; all state changes on posedge.
- start  in  1  synchronous, active-high reset.
- op_valid  in  1  execute stage presents an operation.
- op_ready  out  1  unit can accept; high only in IDLE.
- op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  in  XLEN  rs value: multiplicand / dividend.
- op_b  in  XLEN  rt value: multiplier / divisor.
- flush  in  1  abort an in-flight operation.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  XLEN  MTHI/MTLO data.
- busy  out  1  operation in flight (CALC or FIX).
- done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- div_by_zero  out  1  last completed operation was a divide with op_b = 0; held until next accept.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

## Operation
- States: IDLE, CALC, FIX. Accept = op_valid && op_ready at a posedge.
- Accept: latch opcode and operand signs; signed ops take magnitudes (|min| treated as unsigned 2^(XLEN-1)); counter = XLEN; IDLE→CALC. Divide with op_b = 0: IDLE→FIX directly.
- CALC: multiply = shift-add on 2·XLEN accumulator; divide = restoring shift-subtract yielding quotient and remainder. Counter decrements each cycle; CALC→FIX when counter reaches 1 on that edge (exactly XLEN CALC cycles).
- FIX: apply signs and write HI/LO; done = 1; FIX→IDLE.
  - MULT/MULTU: {HI,LO} = 2·XLEN product; negate if operand signs differ (MULT only).
  - DIV/DIVU: LO = quotient, HI = remainder; DIV: quotient negative iff signs differ, remainder takes dividend sign. min / −1 gives LO = min, HI = 0 (no trap).
  - Divide by zero: HI = op_a, LO = all ones, div_by_zero = 1.
- MTHI/MTLO: in IDLE with no accept on the same edge, hi_we/lo_we load wdata next edge. Accept on the same edge has priority; write dropped. Ignored when busy.
- flush: in CALC or FIX forces IDLE next edge; HI/LO, div_by_zero unchanged; no done. Ignored in IDLE (flush and accept on the same edge: flush wins, no accept).
- start: overrides everything; next edge state IDLE, hi = lo = 0, done = 0, div_by_zero = 0, busy = 0, op_ready = 1.

## Timing
- Accept at edge N; normal op: done high and HI/LO valid after edge N+XLEN+1 (XLEN+1 cycles latency). Divide by zero: after edge N+1.
- busy = 1 from edge N through edge N+XLEN+1 exclusive; op_ready = !busy (combinational from state).
- Back-to-back: op_ready is high in the cycle done is high; a new accept there is legal.
- Outputs hi, lo, done, div_by_zero are registered; no combinational path input→output except none (op_ready from state only).

## Structure
- Shared package mips_pkg: op_code encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), muldiv state enum, XLEN default constant.
- Single module; datapath (accumulator, shift/subtract) and FSM in one file. No sub-module required; sign fix-up may be a function in mips_pkg.

## Test plan
- MULT op_a=0xFFFFFFFD (−3), op_b=7 at edge N -> done at N+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 at edge N -> done after N+1, HI=0x1234, LO=0xFFFFFFFF, div_by_zero=1; next accepted op clears it.
- flush asserted 10 cycles into CALC -> no done, HI/LO keep prior values, op_ready=1 next cycle; start mid-CALC -> HI=LO=0, IDLE.
- hi_we with wdata=0xA5A5A5A5 while busy -> HI unchanged; same in IDLE -> HI=0xA5A5A5A5; hi_we and accept same edge -> write dropped.
- New op presented in done cycle -> accepted, second done exactly XLEN+1 cycles later; XLEN=8 instance: MULT 0x80×0x80 -> HI=0x40, LO=0x00 after 9 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide opcodes, the
// multiply/divide unit state encoding and the default datapath width.
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } mdState_t;

endpackage

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One result bit per CALC cycle; signs are stripped on accept and restored in FIX.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clock,
  input  logic            start,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_code,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  function automatic logic [2*XLEN-1:0] negWide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] negNarrow(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  mdState_t state, nextState;

  logic                   accept;
  logic                   isDivIn, isSignedIn, aNeg, bNeg, bZero;
  logic signed [XLEN-1:0] aSigned, bSigned;
  logic [XLEN-1:0]        aMag, bMag;

  logic                   isDiv, negRes, negRem, dbzOp;
  logic [CNT_W-1:0]       cnt;
  logic [XLEN-1:0]        accHi, accLo, opnd;
  logic [XLEN:0]          mulSum, divShift, divDiff;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        fixHi, fixLo;

  assign op_ready = (state == MD_IDLE);
  assign busy     = (state != MD_IDLE);
  // flush in IDLE blocks an accept on the same edge
  assign accept   = op_valid && (state == MD_IDLE) && !flush;

  assign isDivIn    = op_code[1];
  assign isSignedIn = (op_code == MD_MULT) || (op_code == MD_DIV);
  assign aSigned    = op_a;
  assign bSigned    = op_b;
  assign aNeg       = isSignedIn && (aSigned < 0);
  assign bNeg       = isSignedIn && (bSigned < 0);
  assign aMag       = aNeg ? -op_a : op_a;
  assign bMag       = bNeg ? -op_b : op_b;
  assign bZero      = (op_b == '0);

  always_comb begin
    nextState = state;
    case (state)
      MD_IDLE: if (accept) nextState = (isDivIn && bZero) ? MD_FIX : MD_CALC;
      MD_CALC: begin
        if (flush)                     nextState = MD_IDLE;
        else if (cnt == CNT_W'(1))     nextState = MD_FIX;
      end
      MD_FIX:  nextState = MD_IDLE;
      default: nextState = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (start) state <= MD_IDLE;
    else       state <= nextState;
  end

  // CALC step: multiply adds the multiplicand when the multiplier LSB is set and
  // shifts right; divide shifts the remainder left and subtracts if it fits.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
  assign divShift = {accHi, accLo[XLEN-1]};
  assign divDiff  = divShift - {1'b0, opnd};

  always_ff @(posedge clock) begin
    if (accept) begin
      isDiv  <= isDivIn;
      negRes <= aNeg ^ bNeg;
      negRem <= aNeg;
      dbzOp  <= isDivIn && bZero;
      cnt    <= CNT_W'(XLEN);
      accHi  <= '0;
      if (isDivIn) begin
        accLo <= bZero ? op_a : aMag;
        opnd  <= bMag;
      end else begin
        accLo <= bMag;
        opnd  <= aMag;
      end
    end else if (state == MD_CALC) begin
      cnt <= cnt - CNT_W'(1);
      if (isDiv) begin
        if (!divDiff[XLEN]) begin
          accHi <= divDiff[XLEN-1:0];
          accLo <= {accLo[XLEN-2:0], 1'b1};
        end else begin
          accHi <= divShift[XLEN-1:0];
          accLo <= {accLo[XLEN-2:0], 1'b0};
        end
      end else begin
        accHi <= mulSum[XLEN:1];
        accLo <= {mulSum[0], accLo[XLEN-1:1]};
      end
    end
  end

  // FIX: restore signs; remainder follows the dividend, quotient the sign product
  always_comb begin
    prod  = negWide({accHi, accLo}, negRes);
    fixHi = prod[2*XLEN-1:XLEN];
    fixLo = prod[XLEN-1:0];
    if (dbzOp) begin
      fixHi = accLo;
      fixLo = '1;
    end else if (isDiv) begin
      fixHi = negNarrow(accHi, negRem);
      fixLo = negNarrow(accLo, negRes);
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) div_by_zero <= 1'b0;
      if (state == MD_FIX && !flush) begin
        hi          <= fixHi;
        lo          <= fixLo;
        done        <= 1'b1;
        div_by_zero <= dbzOp;
      end else if (state == MD_IDLE && !accept) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized self-checking bench for mips_muldiv_unit (XLEN=32 and XLEN=8 instances)
// against an arithmetic reference model of MIPS MULT/MULTU/DIV/DIVU semantics.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        start, flush, hiWe, loWe;
  logic [31:0] wdata;

  logic        opValid, opReady, busy, done, dbz;
  logic [1:0]  opCode;
  logic [31:0] opA, opB, hi, lo;

  logic        opValid8, opReady8, busy8, done8, dbz8;
  logic [1:0]  opCode8;
  logic [7:0]  opA8, opB8, hi8, lo8;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clock = ~clock;

  mips_muldiv_unit #(.XLEN(32)) dut32 (
    .clock(clock), .start(start), .op_valid(opValid), .op_ready(opReady),
    .op_code(opCode), .op_a(opA), .op_b(opB), .flush(flush),
    .hi_we(hiWe), .lo_we(loWe), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.XLEN(8)) dut8 (
    .clock(clock), .start(start), .op_valid(opValid8), .op_ready(opReady8),
    .op_code(opCode8), .op_a(opA8), .op_b(opB8), .flush(flush),
    .hi_we(hiWe), .lo_we(loWe), .wdata(wdata[7:0]), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics from plain wide arithmetic on w-bit operands.
  task automatic refOp(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb, sp;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    edz = 1'b0;
    p = 64'd0;
    case (op)
      MD_MULT:  begin sp = sa * sb; p = sp; end
      MD_MULTU: p = ua * ub;
      default:  p = 64'd0;
    endcase
    eh = 32'((p >> w) & mask);
    el = 32'(p & mask);
    if (op[1]) begin
      if (ub == 64'd0) begin
        edz = 1'b1;
        eh  = 32'(ua);
        el  = 32'(mask);
      end else if (op == MD_DIV) begin
        el = 32'(64'(sa / sb) & mask);
        eh = 32'(64'(sa % sb) & mask);
      end else begin
        el = 32'((ua / ub) & mask);
        eh = 32'((ua % ub) & mask);
      end
    end
  endtask

  task automatic waitDone(input int w, output int lat);
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!((w == 32) ? done : done8) && lat < 100);
  endtask

  // Issues at the current time; the next posedge is the accept edge.
  task automatic doOp(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input logic edz, input string tag);
    int lat;
    if (w == 32) begin
      opValid = 1'b1; opCode = op; opA = a; opB = b;
      checkVal({tag, ":rdy"}, opReady, 1);
    end else begin
      opValid8 = 1'b1; opCode8 = op; opA8 = a[7:0]; opB8 = b[7:0];
      checkVal({tag, ":rdy"}, opReady8, 1);
    end
    @(posedge clock); #1;
    opValid = 1'b0; opValid8 = 1'b0;
    checkVal({tag, ":busy"}, (w == 32) ? busy : busy8, 1);
    checkVal({tag, ":dbzclr"}, (w == 32) ? dbz : dbz8, 0);
    waitDone(w, lat);
    checkVal({tag, ":lat"}, lat, edz ? 1 : w + 1);
    checkVal({tag, ":hi"}, (w == 32) ? hi : {24'd0, hi8}, eh);
    checkVal({tag, ":lo"}, (w == 32) ? lo : {24'd0, lo8}, el);
    checkVal({tag, ":dbz"}, (w == 32) ? dbz : dbz8, edz);
  endtask

  function automatic logic [31:0] pickVal(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return m;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom & m;
    endcase
  endfunction

  task automatic rndOp(input int w, input string tag);
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    logic        edz;
    op = 2'($urandom_range(0, 3));
    a  = pickVal(w);
    b  = pickVal(w);
    refOp(w, op, a, b, eh, el, edz);
    doOp(w, op, a, b, eh, el, edz, tag);
  endtask

  initial begin
    int  lat;
    bit  sawDone;
    logic [31:0] eh, el;
    logic        edz;

    start = 1'b1; flush = 1'b0; hiWe = 1'b0; loWe = 1'b0; wdata = '0;
    opValid = 1'b0; opCode = '0; opA = '0; opB = '0;
    opValid8 = 1'b0; opCode8 = '0; opA8 = '0; opB8 = '0;
    repeat (3) @(posedge clock);
    #1 start = 1'b0;
    checkVal("rst:hi", hi, 0);
    checkVal("rst:lo", lo, 0);
    checkVal("rst:done", done, 0);
    checkVal("rst:dbz", dbz, 0);
    checkVal("rst:busy", busy, 0);
    checkVal("rst:rdy", opReady, 1);
    checkVal("rst:rdy8", opReady8, 1);

    // MTHI / MTLO in IDLE
    hiWe = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clock); #1 hiWe = 1'b0;
    checkVal("mthi:hi", hi, 32'hA5A5_A5A5);
    checkVal("mthi:lo", lo, 0);
    loWe = 1'b1; wdata = 32'h5A5A_5A5A;
    @(posedge clock); #1 loWe = 1'b0;
    checkVal("mtlo:lo", lo, 32'h5A5A_5A5A);

    // flush ten cycles into CALC
    opValid = 1'b1; opCode = MD_MULTU; opA = 32'd5; opB = 32'd7;
    @(posedge clock); #1 opValid = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    checkVal("flush:rdy", opReady, 1);
    checkVal("flush:busy", busy, 0);
    sawDone = 1'b0;
    repeat (40) begin @(posedge clock); #1; if (done) sawDone = 1'b1; end
    checkVal("flush:nodone", sawDone, 0);
    checkVal("flush:hi", hi, 32'hA5A5_A5A5);
    checkVal("flush:lo", lo, 32'h5A5A_5A5A);

    // MTHI on the accept edge is dropped, MTHI while busy is ignored
    hiWe = 1'b1; wdata = 32'h1111_1111;
    opValid = 1'b1; opCode = MD_MULTU; opA = 32'd2; opB = 32'd3;
    @(posedge clock); #1 hiWe = 1'b0; opValid = 1'b0;
    checkVal("hiwe_accept:hi", hi, 32'hA5A5_A5A5);
    repeat (3) begin @(posedge clock); #1; end
    hiWe = 1'b1; wdata = 32'h2222_2222;
    @(posedge clock); #1 hiWe = 1'b0;
    checkVal("hiwe_busy:hi", hi, 32'hA5A5_A5A5);
    waitDone(32, lat);
    checkVal("hiwe_op:lat", lat + 4, 33);
    checkVal("hiwe_op:hi", hi, 0);
    checkVal("hiwe_op:lo", lo, 6);

    // directed arithmetic cases, issued back to back in each done cycle
    doOp(32, MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult");
    doOp(32, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu");
    @(posedge clock); #1;
    checkVal("done:pulse", done, 0);
    doOp(32, MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div");
    doOp(32, MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0, "divu");
    doOp(32, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, "divmin");
    doOp(32, MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, "dbz");
    repeat (2) @(posedge clock);
    #1 checkVal("dbz:held", dbz, 1);
    doOp(32, MD_MULT,  32'd6,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, "afterdbz");

    for (int i = 0; i < 30; i++) rndOp(32, $sformatf("rnd32_%0d", i));

    // start in the middle of CALC
    opValid = 1'b1; opCode = MD_DIVU; opA = 32'd1000; opB = 32'd3;
    @(posedge clock); #1 opValid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    checkVal("startcalc:hi", hi, 0);
    checkVal("startcalc:lo", lo, 0);
    checkVal("startcalc:busy", busy, 0);
    checkVal("startcalc:rdy", opReady, 1);
    checkVal("startcalc:done", done, 0);

    // narrow instance
    doOp(8, MD_MULT, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "mult8");
    refOp(8, MD_DIV, 32'h80, 32'hFF, eh, el, edz);
    doOp(8, MD_DIV, 32'h80, 32'hFF, eh, el, edz, "divmin8");
    for (int i = 0; i < 12; i++) rndOp(8, $sformatf("rnd8_%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
